pixel_frame_buffer: RTL and testbench

Parametrised frame buffer that stores a Width×Height image of Channels colour components per pixel. It provides one write port with a ready/valid handshake, one pipelined read port with fixed latency, and a hardware fill engine that clears the whole frame to one colour. It sits between the drawing/processing datapath (writer) and the display scan-out (reader) and replaces the fixed-RGB single-mode memory. All ports are synchronous to one clock.

---
 rtl/frame_buffer_pkg.sv | 16 +
 rtl/frame_ram.sv | 49 ++++
 rtl/pixel_frame_buffer.sv | 221 ++++++++++++++++++++++
 tb/tb_pixel_frame_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buffer_pkg.sv
// -----------------------------------------------------------------------------
// frame_buffer_pkg
// Shared types and constants for the pixel frame buffer.
//   fb_state_t    : fill controller state (IDLE / FILL)
//   READ_LATENCY  : cycles from a read request being presented to its result
// -----------------------------------------------------------------------------
package frame_buffer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } fb_state_t;

    localparam int READ_LATENCY = 2;

endpackage : frame_buffer_pkg

// File: rtl/frame_ram.sv
// -----------------------------------------------------------------------------
// frame_ram
// Simple dual-port RAM: one write port, one read port, registered read data.
// The array carries no reset so it maps onto block RAM. The read is
// read-first: a write and a read of the same address on the same edge
// return the previous content.
// Ports:
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable (rdata_o only updates when set)
//   raddr_i  : read address
//   rdata_o  : registered read data (first read latency stage)
// -----------------------------------------------------------------------------
module frame_ram #(
    parameter int Depth = 76800,
    parameter int AddrW = 17,
    parameter int DataW = 24
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [DataW-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [DataW-1:0] rdata_o
);

    logic [DataW-1:0] mem_q [Depth];
    logic [DataW-1:0] rdata_q;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; non-blocking update gives read-first behaviour
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : frame_ram

// File: rtl/pixel_frame_buffer.sv
// -----------------------------------------------------------------------------
// pixel_frame_buffer
// Width x Height frame store, Channels components of ColorBits each per pixel
// (channel 0 in the LSBs). One ready/valid write port, one fixed-latency read
// port (result valid two cycles after the request is presented), and a fill
// engine that writes one colour to every pixel, one address per cycle.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   wr_valid_i / wr_ready_o    : write handshake (ready only while IDLE)
//   wr_x_i, wr_y_i, wr_pixel_i : write coordinates and data
//   wr_oob_o                   : pulse, accepted write was out of range
//   rd_en_i, rd_x_i, rd_y_i    : read request, accepted every cycle
//   rd_valid_o, rd_pixel_o     : read result (pixel holds when not valid)
//   rd_oob_o                   : read request was out of range, pixel = 0
//   fill_start_i, fill_pixel_i : start a fill with the given colour
//   fill_busy_o, fill_done_o   : fill in progress / completion pulse
// -----------------------------------------------------------------------------
module pixel_frame_buffer
    import frame_buffer_pkg::*;
#(
    parameter int Width     = 320,
    parameter int Height    = 240,
    parameter int ColorBits = 8,
    parameter int Channels  = 3,
    localparam int PW = Channels * ColorBits,
    localparam int XW = $clog2(Width),
    localparam int YW = $clog2(Height),
    localparam int N  = Width * Height,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    input  logic [XW-1:0] wr_x_i,
    input  logic [YW-1:0] wr_y_i,
    input  logic [PW-1:0] wr_pixel_i,
    output logic          wr_oob_o,
    input  logic          rd_en_i,
    input  logic [XW-1:0] rd_x_i,
    input  logic [YW-1:0] rd_y_i,
    output logic          rd_valid_o,
    output logic [PW-1:0] rd_pixel_o,
    output logic          rd_oob_o,
    input  logic          fill_start_i,
    input  logic [PW-1:0] fill_pixel_i,
    output logic          fill_busy_o,
    output logic          fill_done_o
);

    // One extra bit so that a coordinate equal to 2**XW / 2**YW compares cleanly
    localparam logic [XW:0]   WIDTH_X  = (XW + 1)'(Width);
    localparam logic [YW:0]   HEIGHT_Y = (YW + 1)'(Height);
    localparam logic [AW-1:0] WIDTH_A  = AW'(Width);
    localparam logic [AW-1:0] LAST_A   = AW'(N - 1);

    // Fill controller state and registered outputs
    fb_state_t     state_q;
    logic [AW-1:0] fill_addr_q;
    logic [PW-1:0] fill_color_q;
    logic          fill_busy_q;
    logic          fill_done_q;

    // Write path
    logic          wr_accept_s;
    logic          wr_in_range_s;
    logic [AW-1:0] wr_addr_s;
    logic          wr_oob_q;

    // RAM port signals
    logic          ram_we_s;
    logic [AW-1:0] ram_waddr_s;
    logic [PW-1:0] ram_wdata_s;
    logic          ram_re_s;
    logic [AW-1:0] rd_addr_s;
    logic [PW-1:0] ram_rdata_s;

    // Read pipeline
    logic          rd_in_range_s;
    logic          rd_v1_q;
    logic          rd_oob1_q;
    logic          rd_valid_q;
    logic          rd_oob_q;
    logic [PW-1:0] rd_pixel_d;
    logic [PW-1:0] rd_pixel_q;

    assign wr_ready_o  = (state_q == IDLE);
    assign wr_accept_s = wr_valid_i && wr_ready_o;

    // Range checks and linear addresses (product held at AW bits)
    always_comb begin
        wr_in_range_s = ({1'b0, wr_x_i} < WIDTH_X) && ({1'b0, wr_y_i} < HEIGHT_Y);
        rd_in_range_s = ({1'b0, rd_x_i} < WIDTH_X) && ({1'b0, rd_y_i} < HEIGHT_Y);
        wr_addr_s     = (AW'(wr_y_i) * WIDTH_A) + AW'(wr_x_i);
        rd_addr_s     = (AW'(rd_y_i) * WIDTH_A) + AW'(rd_x_i);
    end

    // Write-port mux: the fill engine owns the RAM write port while in FILL
    always_comb begin
        if (state_q == FILL) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = fill_addr_q;
            ram_wdata_s = fill_color_q;
        end else begin
            ram_we_s    = wr_accept_s && wr_in_range_s;
            ram_waddr_s = wr_addr_s;
            ram_wdata_s = wr_pixel_i;
        end
    end

    // Out-of-range reads never enable the RAM
    assign ram_re_s = rd_en_i && rd_in_range_s;

    frame_ram #(
        .Depth (N),
        .AddrW (AW),
        .DataW (PW)
    ) u_frame_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .waddr_i (ram_waddr_s),
        .wdata_i (ram_wdata_s),
        .re_i    (ram_re_s),
        .raddr_i (rd_addr_s),
        .rdata_o (ram_rdata_s)
    );

    // Fill FSM with its registered busy/done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fill_addr_q  <= {AW{1'b0}};
            fill_color_q <= {PW{1'b0}};
            fill_busy_q  <= 1'b0;
            fill_done_q  <= 1'b0;
        end else begin
            fill_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fill_start_i) begin
                        state_q      <= FILL;
                        fill_addr_q  <= {AW{1'b0}};
                        fill_color_q <= fill_pixel_i;
                        fill_busy_q  <= 1'b1;
                    end else begin
                        fill_busy_q  <= 1'b0;
                    end
                end
                FILL: begin
                    // fill_start is deliberately not looked at here
                    if (fill_addr_q == LAST_A) begin
                        state_q     <= IDLE;
                        fill_busy_q <= 1'b0;
                        fill_done_q <= 1'b1;
                    end else begin
                        fill_addr_q <= fill_addr_q + AW'(1);
                        fill_busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    fill_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Out-of-range write flag, one cycle after the accepting edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_oob_q <= 1'b0;
        end else begin
            wr_oob_q <= wr_accept_s && !wr_in_range_s;
        end
    end

    // First read stage: request qualifiers travel alongside the RAM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1_q   <= 1'b0;
            rd_oob1_q <= 1'b0;
        end else begin
            rd_v1_q   <= rd_en_i;
            rd_oob1_q <= rd_en_i && !rd_in_range_s;
        end
    end

    // Output pixel: zero for out-of-range requests, hold when nothing returns
    always_comb begin
        if (rd_v1_q) begin
            if (rd_oob1_q) begin
                rd_pixel_d = {PW{1'b0}};
            end else begin
                rd_pixel_d = ram_rdata_s;
            end
        end else begin
            rd_pixel_d = rd_pixel_q;
        end
    end

    // Second read stage: registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_oob_q   <= 1'b0;
            rd_pixel_q <= {PW{1'b0}};
        end else begin
            rd_valid_q <= rd_v1_q;
            rd_oob_q   <= rd_v1_q && rd_oob1_q;
            rd_pixel_q <= rd_pixel_d;
        end
    end

    assign wr_oob_o    = wr_oob_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_oob_o    = rd_oob_q;
    assign rd_pixel_o  = rd_pixel_q;
    assign fill_busy_o = fill_busy_q;
    assign fill_done_o = fill_done_q;

endmodule : pixel_frame_buffer

// File: tb/tb_pixel_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_pixel_frame_buffer
// Directed bench for a 6x5 frame buffer. Reads push their expected result
// into a scoreboard queue when issued; every clock the returned result (if
// any) is popped and compared, including the cycle it arrived on.
// -----------------------------------------------------------------------------
module tb_pixel_frame_buffer;
    import frame_buffer_pkg::*;

    localparam int W  = 6;
    localparam int H  = 5;
    localparam int N  = W * H;
    localparam int PW = 24;

    typedef struct {
        logic [PW-1:0] pix;
        logic          oob;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [2:0]    wr_x = 3'd0;
    logic [2:0]    wr_y = 3'd0;
    logic [PW-1:0] wr_pixel = 24'h0;
    logic          wr_oob;
    logic          rd_en = 1'b0;
    logic [2:0]    rd_x = 3'd0;
    logic [2:0]    rd_y = 3'd0;
    logic          rd_valid;
    logic [PW-1:0] rd_pixel;
    logic          rd_oob;
    logic          fill_start = 1'b0;
    logic [PW-1:0] fill_pixel = 24'h0;
    logic          fill_busy;
    logic          fill_done;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   c0;

    pixel_frame_buffer #(
        .Width     (W),
        .Height    (H),
        .ColorBits (8),
        .Channels  (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid_i   (wr_valid),
        .wr_ready_o   (wr_ready),
        .wr_x_i       (wr_x),
        .wr_y_i       (wr_y),
        .wr_pixel_i   (wr_pixel),
        .wr_oob_o     (wr_oob),
        .rd_en_i      (rd_en),
        .rd_x_i       (rd_x),
        .rd_y_i       (rd_y),
        .rd_valid_o   (rd_valid),
        .rd_pixel_o   (rd_pixel),
        .rd_oob_o     (rd_oob),
        .fill_start_i (fill_start),
        .fill_pixel_i (fill_pixel),
        .fill_busy_o  (fill_busy),
        .fill_done_o  (fill_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample just after the edge, clear one-shot inputs,
    // and match any returned read against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        wr_valid   = 1'b0;
        rd_en      = 1'b0;
        fill_start = 1'b0;
        if (fill_done === 1'b1) done_cnt++;
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rd_valid_unexpected", 64'(rd_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rd_pixel", 64'(rd_pixel), 64'(e.pix));
                chk("rd_oob", 64'(rd_oob), 64'(e.oob));
                chk("rd_latency", 64'(cyc), 64'(e.due));
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            chk("rd_valid_missing", 64'(rd_valid), 64'd1);
            void'(sb.pop_front());
        end
    endtask

    task automatic wr(input logic [2:0] x, input logic [2:0] y, input logic [PW-1:0] p);
        wr_valid = 1'b1;
        wr_x     = x;
        wr_y     = y;
        wr_pixel = p;
    endtask

    task automatic rd(input logic [2:0] x, input logic [2:0] y, input logic [PW-1:0] p, input logic oob);
        exp_t e;
        rd_en = 1'b1;
        rd_x  = x;
        rd_y  = y;
        e.pix = p;
        e.oob = oob;
        e.due = cyc + READ_LATENCY;
        sb.push_back(e);
    endtask

    initial begin
        // Reset values
        repeat (3) tick();
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_wr_oob", 64'(wr_oob), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_oob", 64'(rd_oob), 64'd0);
        chk("rst_rd_pixel", 64'(rd_pixel), 64'd0);
        chk("rst_fill_busy", 64'(fill_busy), 64'd0);
        chk("rst_fill_done", 64'(fill_done), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic write / read-back
        wr(3'd3, 3'd2, 24'h112233);
        tick();
        chk("wr_oob_inrange", 64'(wr_oob), 64'd0);
        wr(3'd0, 3'd2, 24'hABCDEF);
        rd(3'd3, 3'd2, 24'h112233, 1'b0);
        tick();

        // Out-of-range writes; (6,1) would alias (0,2) if not dropped
        wr(3'd6, 3'd1, 24'hFFFFFF);
        tick();
        chk("wr_oob_x", 64'(wr_oob), 64'd1);
        wr(3'd1, 3'd5, 24'hFFFFFF);
        rd(3'd0, 3'd2, 24'hABCDEF, 1'b0);
        tick();
        chk("wr_oob_y", 64'(wr_oob), 64'd1);
        rd(3'd5, 3'd5, 24'h0, 1'b1);
        tick();
        chk("wr_oob_clear", 64'(wr_oob), 64'd0);
        rd(3'd1, 3'd7, 24'h0, 1'b1);
        tick();
        rd(3'd7, 3'd0, 24'h0, 1'b1);
        tick();
        rd(3'd0, 3'd2, 24'hABCDEF, 1'b0);
        tick();

        // Read during write returns old data; then pixel holds when idle
        wr(3'd3, 3'd3, 24'h000001);
        tick();
        wr(3'd3, 3'd3, 24'h000002);
        rd(3'd3, 3'd3, 24'h000001, 1'b0);
        tick();
        rd(3'd3, 3'd3, 24'h000002, 1'b0);
        repeat (4) tick();
        chk("rd_valid_idle", 64'(rd_valid), 64'd0);
        chk("rd_pixel_hold", 64'(rd_pixel), 64'h000002);

        // Fill with a simultaneous write; second fill_start mid-fill ignored
        done_cnt   = 0;
        c0         = cyc;
        fill_start = 1'b1;
        fill_pixel = 24'h00AA55;
        wr(3'd2, 3'd2, 24'h123456);
        rd(3'd3, 3'd2, 24'h112233, 1'b0);
        tick();
        for (int j = 1; j <= N; j++) begin
            chk("fill_busy_high", 64'(fill_busy), 64'd1);
            chk("fill_wr_ready_low", 64'(wr_ready), 64'd0);
            chk("fill_done_low", 64'(fill_done), 64'd0);
            if (j == 5) begin
                fill_start = 1'b1;
                fill_pixel = 24'h777777;
            end
            wr(3'd4, 3'd4, 24'hDEAD00);
            if (j == 1) begin
                rd(3'd2, 3'd2, 24'h123456, 1'b0);
            end else begin
                rd(3'((j - 2) % W), 3'((j - 2) / W), 24'h00AA55, 1'b0);
            end
            tick();
        end
        chk("fill_len", 64'(cyc - c0), 64'(N + 1));
        chk("fill_end_busy", 64'(fill_busy), 64'd0);
        chk("fill_end_done", 64'(fill_done), 64'd1);
        chk("fill_end_ready", 64'(wr_ready), 64'd1);
        for (int a = 0; a < N; a++) begin
            rd(3'(a % W), 3'(a / W), 24'h00AA55, 1'b0);
            tick();
        end
        repeat (3) tick();
        chk("fill_done_once", 64'(done_cnt), 64'd1);

        // Reset while fill_addr is 10: addresses 0..9 new colour, rest old
        fill_start = 1'b1;
        fill_pixel = 24'h0F0F0F;
        tick();
        repeat (8) tick();
        rd(3'd5, 3'd4, 24'h00AA55, 1'b0);
        tick();
        rd(3'd5, 3'd4, 24'h00AA55, 1'b0);
        tick();
        chk("busy_before_reset", 64'(fill_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("mid_rst_rd_pixel", 64'(rd_pixel), 64'd0);
        chk("mid_rst_fill_busy", 64'(fill_busy), 64'd0);
        chk("mid_rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("mid_rst_fill_done", 64'(fill_done), 64'd0);
        sb.delete();
        done_cnt = 0;
        tick();
        rst_n = 1'b1;
        repeat (N + 5) tick();
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_idle_ready", 64'(wr_ready), 64'd1);
        rd(3'd3, 3'd1, 24'h0F0F0F, 1'b0);
        tick();
        rd(3'd4, 3'd1, 24'h00AA55, 1'b0);
        tick();
        rd(3'd0, 3'd0, 24'h0F0F0F, 1'b0);
        wr(3'd5, 3'd4, 24'h654321);
        tick();
        rd(3'd5, 3'd4, 24'h654321, 1'b0);
        tick();
        repeat (4) tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_pixel_frame_buffer
